// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode hex display scanner with a double-buffered register
// set, dead time between digits, blink, and leading-zero suppression.
module seg7_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int SCAN_CNT     = 200000,
  parameter int DEAD_CYC     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [DIGITS-1:0]     led_en,
  output logic [6:0]            led_seg,
  output logic                  led_dp,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_CNT);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   blink;
    logic                lz_en;
  } disp_buf_t;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h58;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic              phase_q, phase_d;
  disp_buf_t         pend_q, pend_d;
  disp_buf_t         act_q, act_d;
  logic [DIGITS-1:0] led_en_q, led_en_d;
  logic [6:0]        led_seg_q, led_seg_d;
  logic              led_dp_q, led_dp_d;
  logic              frame_done_q, frame_done_d;

  logic              slot_end, frame_end;

  // Scan timing, buffer transfer and blink phase
  always_comb begin
    slot_end  = (cnt_q == CNT_W'(SCAN_CNT - 1));
    frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));

    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = frame_end ? '0 : idx_q + IDX_W'(1);

    pend_d = pend_q;
    if (load) pend_d = '{data: data, dp: dp, blank: blank, blink: blink, lz_en: lz_en};

    // The pending image copied here is the one from before this edge, so a load
    // landing on the boundary edge waits one more frame.
    act_d     = frame_end ? pend_q : act_q;
    blk_cnt_d = blk_cnt_q;
    phase_d   = phase_q;
    if (frame_end) begin
      if (blk_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
        blk_cnt_d = '0;
        phase_d   = ~phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
    frame_done_d = frame_end;
  end

  logic [3:0]        sel_nib;
  logic              sel_dp, sel_blank, sel_blink, sel_lz;
  logic              zero_above, dark_all;
  logic [DIGITS-1:0] lz_dark;
  logic [6:0]        seg_on;

  // Digit select and segment decode for the current slot
  always_comb begin
    zero_above = 1'b1;
    lz_dark    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (act_q.data[4*i +: 4] == 4'h0);
      lz_dark[i] = act_q.lz_en && zero_above && (i != 0);
    end

    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_blink = 1'b0;
    sel_lz    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_nib   = act_q.data[4*i +: 4];
        sel_dp    = act_q.dp[i];
        sel_blank = act_q.blank[i];
        sel_blink = act_q.blink[i];
        sel_lz    = lz_dark[i];
      end
    end

    // Blank and blink kill the dp too; leading-zero suppression keeps it.
    dark_all = sel_blank || (sel_blink && phase_q);
    seg_on   = (dark_all || sel_lz) ? 7'h00 : hex_font(sel_nib);

    led_seg_d = ~seg_on;
    led_dp_d  = ~(sel_dp && !dark_all);
    led_en_d  = (cnt_q < CNT_W'(DEAD_CYC)) ? {DIGITS{1'b1}} : ~(DIGITS'(1) << idx_q);
  end

  // Registered state and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      blk_cnt_q    <= '0;
      phase_q      <= 1'b0;
      pend_q       <= '0;
      act_q        <= '0;
      led_en_q     <= {DIGITS{1'b1}};
      led_seg_q    <= 7'h7F;
      led_dp_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      blk_cnt_q    <= blk_cnt_d;
      phase_q      <= phase_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      led_en_q     <= led_en_d;
      led_seg_q    <= led_seg_d;
      led_dp_q     <= led_dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign led_en     = led_en_q;
  assign led_seg    = led_seg_q;
  assign led_dp     = led_dp_q;
  assign frame_done = frame_done_q;

endmodule
